// File: rtl/noc_link_phy_vc.sv
// ============================================================================
// Module   : noc_link_phy_vc
// Purpose  : Credit-based multi-VC NoC link PHY (TX arbiter + per-VC RX FIFOs).
//            Optional err_o port enabled by NOC_LINK_PHY_VC_ERR_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module noc_link_phy_vc #(
  parameter  int NUM_VC    = 2,
  parameter  int HEADER_W  = 4,
  parameter  int PAYLOAD_W = 64,
  parameter  int RX_DEPTH  = 4,
  localparam int DATA_W    = HEADER_W + PAYLOAD_W,
  localparam int VC_W      = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
  localparam int CRD_W     = $clog2(RX_DEPTH + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_q_i,
  input  logic [NUM_VC-1:0]             tx_wrreq_i,
  input  logic [NUM_VC*HEADER_W-1:0]    tx_header_i,
  input  logic [NUM_VC*PAYLOAD_W-1:0]   tx_payload_i,
  output logic [NUM_VC-1:0]             tx_stall_o,
  output logic                          link_tx_valid_o,
  output logic [VC_W-1:0]               link_tx_vc_o,
  output logic [DATA_W-1:0]             link_tx_data_o,
  input  logic [NUM_VC-1:0]             link_tx_credit_i,
  input  logic                          link_rx_valid_i,
  input  logic [VC_W-1:0]               link_rx_vc_i,
  input  logic [DATA_W-1:0]             link_rx_data_i,
  output logic [NUM_VC-1:0]             link_rx_credit_o,
  input  logic [NUM_VC-1:0]             rx_rdreq_i,
  output logic [NUM_VC*HEADER_W-1:0]    rx_header_o,
  output logic [NUM_VC*PAYLOAD_W-1:0]   rx_payload_o,
  output logic [NUM_VC-1:0]             rx_fifo_empty_o
`ifdef NOC_LINK_PHY_VC_ERR_EN
  ,
  output logic [2*NUM_VC-1:0]           err_o
`endif
);

  localparam int               C_PTR_W    = $clog2(RX_DEPTH);
  localparam logic [CRD_W-1:0] C_FULL_CRD = CRD_W'(RX_DEPTH);

  // ---------------------------------------------------------------- TX side
  logic [NUM_VC-1:0] r_hold_valid;
  logic [DATA_W-1:0] r_hold   [NUM_VC];
  logic [CRD_W-1:0]  r_credit [NUM_VC];
  logic [VC_W-1:0]   r_rr_ptr;

  logic [NUM_VC-1:0] w_eligible;
  logic [NUM_VC-1:0] w_grant;
  logic [NUM_VC-1:0] w_load;
  logic              w_grant_any;
  logic [VC_W-1:0]   w_grant_vc;

  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      w_eligible[v] = r_hold_valid[v] && (r_credit[v] != '0);
    end
  end

  // Round-robin: first eligible VC at or above rr_ptr, wrapping modulo NUM_VC.
  always_comb begin : p_arb
    int idx;
    idx         = 0;
    w_grant     = '0;
    w_grant_any = 1'b0;
    w_grant_vc  = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      idx = (int'(r_rr_ptr) + i) % NUM_VC;
      if (!w_grant_any && w_eligible[idx]) begin
        w_grant_any  = 1'b1;
        w_grant[idx] = 1'b1;
        w_grant_vc   = VC_W'(idx);
      end
    end
  end

  assign tx_stall_o = r_hold_valid & ~w_grant;
  assign w_load     = tx_wrreq_i & ~tx_stall_o;

  always_ff @(posedge clk_i or negedge rst_q_i) begin
    if (!rst_q_i) begin
      r_hold_valid    <= '0;
      r_rr_ptr        <= '0;
      link_tx_valid_o <= 1'b0;
      link_tx_vc_o    <= '0;
      link_tx_data_o  <= '0;
      for (int v = 0; v < NUM_VC; v++) begin
        r_credit[v] <= C_FULL_CRD;
      end
    end else begin
      r_hold_valid    <= w_load | (r_hold_valid & ~w_grant);
      link_tx_valid_o <= w_grant_any;
      if (w_grant_any) begin
        link_tx_vc_o   <= w_grant_vc;
        link_tx_data_o <= r_hold[w_grant_vc];
        r_rr_ptr       <= (w_grant_vc == VC_W'(NUM_VC - 1)) ? '0 : w_grant_vc + VC_W'(1);
      end
      for (int v = 0; v < NUM_VC; v++) begin
        case ({w_grant[v], link_tx_credit_i[v]})
          2'b10:   r_credit[v] <= r_credit[v] - CRD_W'(1);
          2'b01:   if (r_credit[v] != C_FULL_CRD) r_credit[v] <= r_credit[v] + CRD_W'(1);
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int v = 0; v < NUM_VC; v++) begin
      if (w_load[v]) begin
        r_hold[v] <= {tx_header_i[v*HEADER_W +: HEADER_W], tx_payload_i[v*PAYLOAD_W +: PAYLOAD_W]};
      end
    end
  end

  // ---------------------------------------------------------------- RX side
  logic [DATA_W-1:0]  r_mem    [NUM_VC][RX_DEPTH];
  logic [C_PTR_W:0]   r_wr_ptr [NUM_VC];
  logic [C_PTR_W:0]   r_rd_ptr [NUM_VC];

  logic [NUM_VC-1:0]  w_full;
  logic [NUM_VC-1:0]  w_nonempty;
  logic [NUM_VC-1:0]  w_wr;
  logic [NUM_VC-1:0]  w_pop;
  logic               w_vc_bad;

  // Pop looks only at pre-edge pointers, so a flit is never written and popped on one edge.
  always_comb begin
    w_vc_bad = link_rx_valid_i && (int'(link_rx_vc_i) >= NUM_VC);
    for (int v = 0; v < NUM_VC; v++) begin
      w_nonempty[v] = (r_wr_ptr[v] != r_rd_ptr[v]);
      w_full[v]     = (r_wr_ptr[v][C_PTR_W] != r_rd_ptr[v][C_PTR_W]) &&
                      (r_wr_ptr[v][C_PTR_W-1:0] == r_rd_ptr[v][C_PTR_W-1:0]);
      w_wr[v]       = link_rx_valid_i && (int'(link_rx_vc_i) == v) && !w_full[v];
      w_pop[v]      = w_nonempty[v] && (rx_fifo_empty_o[v] || rx_rdreq_i[v]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_q_i) begin
    if (!rst_q_i) begin
      rx_fifo_empty_o  <= '1;
      link_rx_credit_o <= '0;
      for (int v = 0; v < NUM_VC; v++) begin
        r_wr_ptr[v] <= '0;
        r_rd_ptr[v] <= '0;
      end
    end else begin
      link_rx_credit_o <= w_pop;
      for (int v = 0; v < NUM_VC; v++) begin
        if (w_wr[v]) r_wr_ptr[v] <= r_wr_ptr[v] + (C_PTR_W+1)'(1);
        if (w_pop[v]) begin
          r_rd_ptr[v]        <= r_rd_ptr[v] + (C_PTR_W+1)'(1);
          rx_fifo_empty_o[v] <= 1'b0;
        end else if (rx_rdreq_i[v]) begin
          rx_fifo_empty_o[v] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int v = 0; v < NUM_VC; v++) begin
      if (w_wr[v]) r_mem[v][r_wr_ptr[v][C_PTR_W-1:0]] <= link_rx_data_i;
      if (w_pop[v]) begin
        rx_header_o[v*HEADER_W +: HEADER_W]    <= r_mem[v][r_rd_ptr[v][C_PTR_W-1:0]][DATA_W-1 -: HEADER_W];
        rx_payload_o[v*PAYLOAD_W +: PAYLOAD_W] <= r_mem[v][r_rd_ptr[v][C_PTR_W-1:0]][PAYLOAD_W-1:0];
      end
    end
  end

`ifdef NOC_LINK_PHY_VC_ERR_EN
  // Sticky: low half flags RX overruns / bad VC, high half flags credit overflow.
  always_ff @(posedge clk_i or negedge rst_q_i) begin
    if (!rst_q_i) begin
      err_o <= '0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        if ((link_rx_valid_i && (int'(link_rx_vc_i) == v) && w_full[v]) || (v == 0 && w_vc_bad)) begin
          err_o[v] <= 1'b1;
        end
        if (link_tx_credit_i[v] && !w_grant[v] && (r_credit[v] == C_FULL_CRD)) begin
          err_o[NUM_VC+v] <= 1'b1;
        end
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_noc_link_phy_vc.sv
// Self-checking bench for noc_link_phy_vc (NUM_VC=2, RX_DEPTH=4), scoreboard queues per scenario.
`default_nettype none

module tb_noc_link_phy_vc;

  localparam int NUM_VC    = 2;
  localparam int HEADER_W  = 4;
  localparam int PAYLOAD_W = 64;
  localparam int RX_DEPTH  = 4;
  localparam int DATA_W    = HEADER_W + PAYLOAD_W;
  localparam int VC_W      = 1;

  int checks = 0;
  int errors = 0;

  logic                        clk = 1'b0;
  logic                        rst_q = 1'b0;
  logic [NUM_VC-1:0]           tx_wrreq = '0;
  logic [NUM_VC*HEADER_W-1:0]  tx_header = '0;
  logic [NUM_VC*PAYLOAD_W-1:0] tx_payload = '0;
  logic [NUM_VC-1:0]           tx_stall;
  logic                        link_tx_valid;
  logic [VC_W-1:0]             link_tx_vc;
  logic [DATA_W-1:0]           link_tx_data;
  logic [NUM_VC-1:0]           link_tx_credit;
  logic                        link_rx_valid;
  logic [VC_W-1:0]             link_rx_vc;
  logic [DATA_W-1:0]           link_rx_data;
  logic [NUM_VC-1:0]           link_rx_credit;
  logic [NUM_VC-1:0]           rx_rdreq = '0;
  logic [NUM_VC*HEADER_W-1:0]  rx_header;
  logic [NUM_VC*PAYLOAD_W-1:0] rx_payload;
  logic [NUM_VC-1:0]           rx_empty;
`ifdef NOC_LINK_PHY_VC_ERR_EN
  logic [2*NUM_VC-1:0]         err;
`endif

  logic                        loop_en = 1'b0;
  logic [NUM_VC-1:0]           drv_tx_credit = '0;
  logic                        drv_rx_valid = 1'b0;
  logic [VC_W-1:0]             drv_rx_vc = '0;
  logic [DATA_W-1:0]           drv_rx_data = '0;

  // Loopback mode ties this PHY's TX to its own RX, credits included.
  assign link_rx_valid  = loop_en ? link_tx_valid  : drv_rx_valid;
  assign link_rx_vc     = loop_en ? link_tx_vc     : drv_rx_vc;
  assign link_rx_data   = loop_en ? link_tx_data   : drv_rx_data;
  assign link_tx_credit = loop_en ? link_rx_credit : drv_tx_credit;

  always #5 clk = ~clk;

  noc_link_phy_vc #(
    .NUM_VC(NUM_VC), .HEADER_W(HEADER_W), .PAYLOAD_W(PAYLOAD_W), .RX_DEPTH(RX_DEPTH)
  ) dut (
    .clk_i           (clk),
    .rst_q_i         (rst_q),
    .tx_wrreq_i      (tx_wrreq),
    .tx_header_i     (tx_header),
    .tx_payload_i    (tx_payload),
    .tx_stall_o      (tx_stall),
    .link_tx_valid_o (link_tx_valid),
    .link_tx_vc_o    (link_tx_vc),
    .link_tx_data_o  (link_tx_data),
    .link_tx_credit_i(link_tx_credit),
    .link_rx_valid_i (link_rx_valid),
    .link_rx_vc_i    (link_rx_vc),
    .link_rx_data_i  (link_rx_data),
    .link_rx_credit_o(link_rx_credit),
    .rx_rdreq_i      (rx_rdreq),
    .rx_header_o     (rx_header),
    .rx_payload_o    (rx_payload),
    .rx_fifo_empty_o (rx_empty)
`ifdef NOC_LINK_PHY_VC_ERR_EN
    ,
    .err_o           (err)
`endif
  );

  function automatic logic [DATA_W-1:0] mk(int v, int n);
    logic [DATA_W-1:0] d;
    d = {HEADER_W'(n), 32'(v + 32'h5A00), 32'(n)};
    return d;
  endfunction

  function automatic logic [DATA_W-1:0] rx_out(int v);
    return {rx_header[v*HEADER_W +: HEADER_W], rx_payload[v*PAYLOAD_W +: PAYLOAD_W]};
  endfunction

  task automatic set_tx(int v, logic [DATA_W-1:0] d);
    tx_header[v*HEADER_W +: HEADER_W]    = d[DATA_W-1 -: HEADER_W];
    tx_payload[v*PAYLOAD_W +: PAYLOAD_W] = d[PAYLOAD_W-1:0];
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_q = 1'b0; loop_en = 1'b0; tx_wrreq = '0; rx_rdreq = '0;
    drv_tx_credit = '0; drv_rx_valid = 1'b0; drv_rx_vc = '0; drv_rx_data = '0;
    repeat (2) @(negedge clk);
    rst_q = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    tx_wrreq = 2'b01; set_tx(0, mk(0, 1));
    drv_rx_valid = 1'b1; drv_rx_data = mk(0, 9);
    @(negedge clk);
    tx_wrreq = '0; drv_rx_valid = 1'b0;
    @(negedge clk);
    checks++; if (link_tx_valid !== 1'b1 || link_tx_data !== mk(0, 1)) begin errors++;
      $display("FAIL pre_reset_tx: valid=%b data=%h want 1 %h", link_tx_valid, link_tx_data, mk(0, 1)); end
    checks++; if (rx_empty !== 2'b10 || rx_out(0) !== mk(0, 9)) begin errors++;
      $display("FAIL pre_reset_rx: empty=%b data=%h want 10 %h", rx_empty, rx_out(0), mk(0, 9)); end
    // Asynchronous assertion mid-cycle
    @(posedge clk); #2 rst_q = 1'b0; #1;
    checks++; if (tx_stall !== 2'b00) begin errors++; $display("FAIL reset_stall: got %b want 00", tx_stall); end
    checks++; if (rx_empty !== 2'b11) begin errors++; $display("FAIL reset_empty: got %b want 11", rx_empty); end
    checks++; if (link_tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", link_tx_valid); end
    checks++; if (link_rx_credit !== 2'b00) begin errors++; $display("FAIL reset_rx_credit: got %b want 00", link_rx_credit); end
    checks++; if (link_tx_vc !== 1'b0 || link_tx_data !== '0) begin errors++;
      $display("FAIL reset_tx_bus: vc=%b data=%h want 0 0", link_tx_vc, link_tx_data); end
`ifdef NOC_LINK_PHY_VC_ERR_EN
    checks++; if (err !== '0) begin errors++; $display("FAIL reset_err: got %b want 0000", err); end
`endif
    @(negedge clk); rst_q = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (tx_stall !== 2'b00 || rx_empty !== 2'b11 || link_tx_valid !== 1'b0) begin errors++;
      $display("FAIL post_reset_idle: stall=%b empty=%b valid=%b want 00 11 0", tx_stall, rx_empty, link_tx_valid); end
  endtask

  task automatic test_credit_stall();
    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] exp;
    int sent;
    apply_reset();
    // Two surplus credits on a full counter must saturate, not extend the window.
    drv_tx_credit = 2'b01;
    repeat (2) @(negedge clk);
    drv_tx_credit = '0;
`ifdef NOC_LINK_PHY_VC_ERR_EN
    checks++; if (err !== 4'b0100) begin errors++; $display("FAIL credit_overflow_err: got %b want 0100", err); end
`endif
    sent = 0;
    for (int c = 0; c < 14; c++) begin
      if (link_tx_valid) begin
        sent++;
        exp = '0;
        if (q.size() != 0) exp = q.pop_front();
        checks++; if (link_tx_vc !== 1'b0 || link_tx_data !== exp) begin errors++;
          $display("FAIL credit_flit%0d: vc=%b data=%h want 0 %h", sent, link_tx_vc, link_tx_data, exp); end
      end
      if (c == 5) begin
        checks++; if (tx_stall[0] !== 1'b1) begin errors++; $display("FAIL stall_at_zero_credit: got %b want 1", tx_stall[0]); end
      end
      tx_wrreq = (c < 6) ? 2'b01 : 2'b00;
      if (c < 6) set_tx(0, mk(0, c + 1));
      if (c < 5) q.push_back(mk(0, c + 1));
      @(negedge clk);
    end
    checks++; if (sent !== 4 || tx_stall !== 2'b01 || q.size() !== 1) begin errors++;
      $display("FAIL credit_window: sent=%0d stall=%b pending=%0d want 4 01 1", sent, tx_stall, q.size()); end
    drv_tx_credit = 2'b01;
    @(negedge clk);
    drv_tx_credit = '0;
    checks++; if (link_tx_valid !== 1'b0) begin errors++; $display("FAIL credit_early_send: got %b want 0", link_tx_valid); end
    @(negedge clk);
    exp = '0;
    if (q.size() != 0) exp = q.pop_front();
    checks++; if (link_tx_valid !== 1'b1 || link_tx_vc !== 1'b0 || link_tx_data !== exp) begin errors++;
      $display("FAIL credit_resume: valid=%b vc=%b data=%h want 1 0 %h", link_tx_valid, link_tx_vc, link_tx_data, exp); end
    @(negedge clk);
    checks++; if (link_tx_valid !== 1'b0 || tx_stall !== 2'b00) begin errors++;
      $display("FAIL credit_drained: valid=%b stall=%b want 0 00", link_tx_valid, tx_stall); end
  endtask

  task automatic test_round_robin();
    logic [DATA_W-1:0] q0[$];
    logic [DATA_W-1:0] q1[$];
    logic [DATA_W-1:0] exp;
    logic exp_vc;
    int n0, n1;
    apply_reset();
    loop_en = 1'b1; rx_rdreq = 2'b11;
    exp_vc = 1'b0; n0 = 0; n1 = 0;
    for (int c = 0; c < 24; c++) begin
      if (link_tx_valid) begin
        exp = '0;
        if (exp_vc == 1'b0 && q0.size() != 0) exp = q0.pop_front();
        if (exp_vc == 1'b1 && q1.size() != 0) exp = q1.pop_front();
        checks++; if (link_tx_vc !== exp_vc || link_tx_data !== exp) begin errors++;
          $display("FAIL rr_cycle%0d: vc=%b data=%h want %b %h", c, link_tx_vc, link_tx_data, exp_vc, exp); end
        if (exp_vc) n1++; else n0++;
        exp_vc = ~exp_vc;
      end
      for (int v = 0; v < NUM_VC; v++) begin
        tx_wrreq[v] = !tx_stall[v];
        if (!tx_stall[v]) begin
          set_tx(v, mk(v, c));
          if (v == 0) q0.push_back(mk(v, c)); else q1.push_back(mk(v, c));
        end
      end
      @(negedge clk);
    end
    tx_wrreq = '0;
    checks++; if (n0 < 10 || n1 < 10 || (n0 - n1) > 1 || (n1 - n0) > 1) begin errors++;
      $display("FAIL rr_fairness: vc0=%0d vc1=%0d want both >=10 and within 1", n0, n1); end
  endtask

  task automatic test_loopback();
    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] exp;
    int cr0, cr1, got;
    apply_reset();
    loop_en = 1'b1;
    cr0 = 0; cr1 = 0; got = 0;
    for (int c = 0; c < 16; c++) begin
      if (c == 3) begin
        checks++; if (rx_empty[1] !== 1'b1) begin errors++; $display("FAIL loop_empty_edge3: got %b want 1", rx_empty[1]); end
      end
      if (c == 4) begin
        checks++; if (rx_empty[1] !== 1'b0) begin errors++; $display("FAIL loop_empty_edge4: got %b want 0", rx_empty[1]); end
      end
      cr0 += int'(link_rx_credit[0]);
      cr1 += int'(link_rx_credit[1]);
      if (!rx_empty[1]) begin
        got++;
        exp = '0;
        if (q.size() != 0) exp = q.pop_front();
        checks++; if (rx_out(1) !== exp) begin errors++; $display("FAIL loop_rx%0d: got %h want %h", got, rx_out(1), exp); end
        rx_rdreq[1] = 1'b1;
      end else begin
        rx_rdreq[1] = 1'b0;
      end
      if (c < 3) begin
        tx_wrreq = 2'b10;
        set_tx(1, DATA_W'(32'hA1 + c));
        q.push_back(DATA_W'(32'hA1 + c));
      end else begin
        tx_wrreq = '0;
      end
      @(negedge clk);
    end
    rx_rdreq = '0;
    checks++; if (got !== 3 || q.size() !== 0 || cr1 !== 3 || cr0 !== 0) begin errors++;
      $display("FAIL loop_totals: popped=%0d left=%0d credits=%0d/%0d want 3 0 3/0", got, q.size(), cr1, cr0); end
    checks++; if (rx_empty !== 2'b11 || tx_stall !== 2'b00) begin errors++;
      $display("FAIL loop_idle: empty=%b stall=%b want 11 00", rx_empty, tx_stall); end
  endtask

  task automatic test_rx_fifo();
    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] exp;
    int cr, got;
    apply_reset();
    cr = 0; got = 0;
    for (int c = 0; c < 8; c++) begin
      cr += int'(link_rx_credit[0]);
      drv_rx_valid = (c < 4);
      drv_rx_vc = 1'b0;
      drv_rx_data = mk(0, 10 + c);
      if (c < 4) q.push_back(mk(0, 10 + c));
      @(negedge clk);
    end
    checks++; if (rx_empty[0] !== 1'b0 || rx_out(0) !== mk(0, 10) || cr !== 1) begin errors++;
      $display("FAIL rxfifo_idle: empty=%b data=%h credits=%0d want 0 %h 1", rx_empty[0], rx_out(0), cr, mk(0, 10)); end
    // rdreq stays high past the last flit; the trailing requests must be ignored.
    rx_rdreq[0] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      cr += int'(link_rx_credit[0]);
      if (!rx_empty[0]) begin
        got++;
        exp = '0;
        if (q.size() != 0) exp = q.pop_front();
        checks++; if (rx_out(0) !== exp) begin errors++; $display("FAIL rxfifo_read%0d: got %h want %h", got, rx_out(0), exp); end
      end
      @(negedge clk);
    end
    rx_rdreq = '0;
    checks++; if (got !== 4 || rx_empty !== 2'b11 || cr !== 4 || q.size() !== 0) begin errors++;
      $display("FAIL rxfifo_totals: reads=%0d empty=%b credits=%0d left=%0d want 4 11 4 0", got, rx_empty, cr, q.size()); end
  endtask

`ifdef NOC_LINK_PHY_VC_ERR_EN
  task automatic test_err();
    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] exp;
    int got;
    apply_reset();
    got = 0;
    for (int c = 0; c < 8; c++) begin
      if (c == 5) begin
        checks++; if (err !== 4'b0000) begin errors++; $display("FAIL err_before_overrun: got %b want 0000", err); end
      end
      drv_rx_valid = (c < 6);
      drv_rx_vc = 1'b0;
      drv_rx_data = mk(0, 20 + c);
      if (c < 5) q.push_back(mk(0, 20 + c));
      @(negedge clk);
    end
    checks++; if (err !== 4'b0001) begin errors++; $display("FAIL err_overrun: got %b want 0001", err); end
    rx_rdreq[0] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (!rx_empty[0]) begin
        got++;
        exp = '0;
        if (q.size() != 0) exp = q.pop_front();
        checks++; if (rx_out(0) !== exp) begin errors++; $display("FAIL err_read%0d: got %h want %h", got, rx_out(0), exp); end
      end
      @(negedge clk);
    end
    rx_rdreq = '0;
    checks++; if (got !== 5 || rx_empty[0] !== 1'b1 || err !== 4'b0001) begin errors++;
      $display("FAIL err_sticky: reads=%0d empty=%b err=%b want 5 1 0001", got, rx_empty[0], err); end
  endtask
`endif

  initial begin
    test_reset();
    test_credit_stall();
    test_round_robin();
    test_loopback();
    test_rx_fifo();
`ifdef NOC_LINK_PHY_VC_ERR_EN
    test_err();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/noc_link_phy_vc.md
Name: noc_link_phy_vc

Overview:
Multi-virtual-channel, credit-based, synchronous NoC link PHY. It replaces the single-channel pointer-exchange link with NUM_VC independent channels that share one physical flit bus per direction.
- TX side: one holding register per VC, a round-robin arbiter, and per-VC credit counters.
- RX side: one RX FIFO per VC, a prefetch output register per VC, and registered credit-return pulses.
- Sits between a router port and the inter-tile link wires.

Parameters:
NUM_VC, 2, number of virtual channels (1..8).
HEADER_W, 4, header width per flit.
PAYLOAD_W, 64, payload width per flit.
RX_DEPTH, 4, RX FIFO depth per VC; power of two, at least 2. Also the initial credit count.
Derived, not overridable: DATA_W = HEADER_W+PAYLOAD_W; VC_W = max(1,clog2(NUM_VC)); CRD_W = clog2(RX_DEPTH+1).

Ports:
clk_i  in  1  clock
rst_q_i  in  1  reset, asynchronous, active-low
tx_wrreq_i  in  NUM_VC  per-VC write request
tx_header_i  in  NUM_VC*HEADER_W  per-VC header; VC v at [v*HEADER_W +: HEADER_W]
tx_payload_i  in  NUM_VC*PAYLOAD_W  per-VC payload, same packing
tx_stall_o  out  NUM_VC  per-VC holding register busy
link_tx_valid_o  out  1  flit valid on link
link_tx_vc_o  out  VC_W  VC of flit
link_tx_data_o  out  DATA_W  {header,payload}
link_tx_credit_i  in  NUM_VC  credit return from far side, 1 pulse = 1 slot
link_rx_valid_i  in  1  incoming flit valid
link_rx_vc_i  in  VC_W  incoming VC
link_rx_data_i  in  DATA_W  incoming {header,payload}
link_rx_credit_o  out  NUM_VC  credit return to far side
rx_rdreq_i  in  NUM_VC  per-VC pop of output register
rx_header_o  out  NUM_VC*HEADER_W  per-VC registered header
rx_payload_o  out  NUM_VC*PAYLOAD_W  per-VC registered payload
rx_fifo_empty_o  out  NUM_VC  per-VC output register empty

Behaviour:
Reset (rst_q_i low, asynchronous):
- hold_valid=0, credits=RX_DEPTH, rr_ptr=0, FIFO pointers=0.
- link_tx_valid_o=0, link_tx_vc_o=0, link_tx_data_o=0, link_rx_credit_o=0.
- rx_fifo_empty_o=all 1. rx_header_o/rx_payload_o have no reset.
- Reset mid-transfer discards all held, queued and in-flight flits and restores full credits. Both link ends must be reset together.

TX holding register:
- eligible[v] = hold_valid[v] && credit[v]!=0.
- grant = first eligible VC scanning from rr_ptr upward, modulo NUM_VC. At most one grant per cycle.
- tx_stall_o[v] = hold_valid[v] && !grant[v]. This is combinational from registers only.
- tx_wrreq_i[v] with !tx_stall_o[v]: the flit loads into hold[v] at the edge. Refill in the same cycle as the grant is allowed, giving 1 flit/cycle per VC.
- tx_wrreq_i[v] while stalled: the flit is ignored. This is a protocol violation.

TX link output and arbitration:
- On grant v, at the edge: link_tx_valid_o<=1, link_tx_vc_o<=v, link_tx_data_o<=hold[v]; hold_valid[v] cleared unless refilled; rr_ptr<=(v+1)%NUM_VC.
- No grant: link_tx_valid_o<=0; vc and data hold their values.
- Latency: wrreq at edge k gives link valid after edge k+1.

Credit counters:
- Grant and credit_i in the same cycle: counter unchanged.
- credit_i alone: +1.
- Grant alone: -1.
- A counter never underflows, because a grant requires credit!=0.
- Credit above RX_DEPTH is an overflow. It saturates at RX_DEPTH; see the optional feature for reporting.

RX path:
- link_rx_valid_i writes link_rx_data_i into FIFO[link_rx_vc_i] at the edge.
- A write to a full FIFO is dropped. Credit protocol guarantees this never happens.
- link_rx_vc_i >= NUM_VC is dropped.

Output register and pop, per VC:
- pop[v] = fifo_nonempty[v] && (rx_fifo_empty_o[v] || rx_rdreq_i[v]).
- On pop, the FIFO head loads into the output register and rx_fifo_empty_o[v]<=0.
- If rx_rdreq_i[v] && FIFO empty: rx_fifo_empty_o[v]<=1.
- rx_rdreq_i while empty is ignored.
- A simultaneous FIFO write and pop on the same VC is legal. A flit written at edge k is never popped at edge k.

Credit return:
- link_rx_credit_o[v]<=pop[v], a registered 1-cycle pulse per popped flit.
- The output register is extra storage and is not credited.

Ordering and latency:
- Order is preserved per VC. There is no ordering guarantee across VCs.
- Link flit at edge k: visible at the output after edge k+1; credit pulse after edge k+1.

Optional Feature:
NOC_LINK_PHY_VC_ERR_EN defined:
- Adds output err_o [2*NUM_VC-1:0], reset 0, sticky until reset.
- err_o[v] set on an RX write to full FIFO v, or on link_rx_vc_i>=NUM_VC (sets bit 0).
- err_o[NUM_VC+v] set on a credit overflow for VC v.

Undefined:
- No err_o port.
- Errors are silently dropped or saturated as described under Behaviour.

Test Plan:
- Reset with NUM_VC=2, RX_DEPTH=4 -> tx_stall_o=00, rx_fifo_empty_o=11, link_tx_valid_o=0, link_rx_credit_o=00.
- 6 back-to-back VC0 writes, no credit return -> exactly 4 link flits with vc=0, then tx_stall_o[0]=1 holding flit 5. One link_tx_credit_i[0] pulse -> flit 5 sent the next cycle.
- Both VCs loaded every cycle, credits looped back -> link_tx_vc_o sequence 0,1,0,1,... and no VC starved.
- TX looped to RX, VC1 writes of 0xA1,0xA2,0xA3 -> rx_fifo_empty_o[1] falls 3 edges after the first wrreq. Popped in order A1,A2,A3, with one credit pulse per flit.
- 4 RX flits to VC0, no reads -> out reg=flit1, FIFO holds 3, one credit pulse. 4 consecutive rx_rdreq_i[0] -> flits 1..4 in order, then empty=1. Credit pulses total 4.
- With NOC_LINK_PHY_VC_ERR_EN, force 5 RX flits to VC0 without credits and no reads -> the 6th write is dropped and err_o[0]=1, staying set after subsequent reads.
